pe_dbuf_shared_bus: RTL

//  Parametrised systolic-array PE with one shared B/partial-sum bus, a double-buffered

---
 rtl/pe_dbuf_shared_bus.sv | 91 +++++++++
 1 files changed

// File: rtl/pe_dbuf_shared_bus.sv
// Systolic-array PE: shared B/partial-sum bus, shadow+active weight, op code carried with data.
// Optional macro PE_SAT_EN: saturate COMPUTE overflow instead of wrapping.
module pe_dbuf_shared_bus #(
    parameter int A_W  = 8,
    parameter int B_W  = 8,
    parameter int PS_W = 16
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            valid_i,
    input  logic [1:0]      op_i,
    input  logic [A_W-1:0]  a_i,
    input  logic [PS_W-1:0] bps_i,
    input  logic            ovf_clr_i,
    output logic            valid_o,
    output logic [1:0]      op_o,
    output logic [A_W-1:0]  a_o,
    output logic [PS_W-1:0] bps_o,
    output logic            ovf_o
);

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_LOAD_B  = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_SWAP    = 2'b11
    } op_t;

    logic [B_W-1:0]         shadow_b;
    logic [B_W-1:0]         active_b;
    logic signed [A_W+B_W-1:0] prod;
    logic signed [PS_W:0]   sum;
    logic                   add_ovf;
    logic [PS_W-1:0]        result;
    logic                   is_compute;

    // The product always fits in A_W+B_W bits; one extra bit on the sum exposes add overflow.
    assign prod       = (A_W+B_W)'($signed(a_i)) * (A_W+B_W)'($signed(active_b));
    assign sum        = (PS_W+1)'(prod) + (PS_W+1)'($signed(bps_i));
    assign add_ovf    = sum[PS_W] ^ sum[PS_W-1];
    assign is_compute = valid_i && (op_t'(op_i) == OP_COMPUTE);

    always_comb begin
        result = sum[PS_W-1:0];
`ifdef PE_SAT_EN
        if (add_ovf) begin
            result = sum[PS_W] ? {1'b1, {(PS_W-1){1'b0}}} : {1'b0, {(PS_W-1){1'b1}}};
        end
`else
        result = sum[PS_W-1:0];
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_o  <= 1'b0;
            op_o     <= '0;
            a_o      <= '0;
            bps_o    <= '0;
            ovf_o    <= 1'b0;
            shadow_b <= '0;
            active_b <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                op_o <= op_i;
                a_o  <= a_i;
                case (op_t'(op_i))
                    OP_NOP:     bps_o <= bps_i;
                    OP_LOAD_B: begin
                        shadow_b <= bps_i[B_W-1:0];
                        bps_o    <= PS_W'(bps_i[B_W-1:0]);
                    end
                    OP_COMPUTE: bps_o <= result;
                    OP_SWAP: begin
                        active_b <= shadow_b;
                        bps_o    <= '0;
                    end
                    default:    bps_o <= bps_i;
                endcase
            end
            // A fresh overflow takes priority over a clear in the same cycle.
            if (is_compute && add_ovf) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule
